// File: rtl/rgmii_pkg.sv
// Shared RGMII/UDP header types and constants. Every header struct is laid out
// so that wire byte k of the header sits at bits [8k+7:8k].
package rgmii_pkg;

  typedef struct packed {
    logic [1:0][7:0] checksum;
    logic [1:0][7:0] length;
    logic [1:0][7:0] port_destination;
    logic [1:0][7:0] port_source;
  } udp_header_t;

  typedef struct packed {
    udp_header_t     udp;
    logic [3:0][7:0] ip_destination;
    logic [3:0][7:0] ip_source;
    logic [1:0][7:0] header_checksum;
    logic [7:0]      protocol;
    logic [7:0]      ttl;
    logic [1:0][7:0] flags_fragment;
    logic [1:0][7:0] identification;
    logic [1:0][7:0] total_length;
    logic [7:0]      dscp_ecn;
    logic [7:0]      version_ihl;
  } ipv4_header_t;

  typedef struct packed {
    ipv4_header_t    ipv4;
    logic [1:0][7:0] eth_type_length;
    logic [5:0][7:0] mac_source;
    logic [5:0][7:0] mac_destination;
  } ethernet_header_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
  localparam int          UDP_HDR_BYTES = 8;
  localparam int          HDR_BYTES     = $bits(ethernet_header_t) / 8;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

endpackage

// File: rtl/ip_csum_acc.sv
// Streaming 16-bit ones-complement accumulator with end-around carry.
// first_i restarts the sum with word_i; sum_o is the fully folded result.
module ip_csum_acc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        first_i,
  input  logic [15:0] word_i,
  output logic [15:0] sum_o
);

  logic [16:0] acc_q, acc_d;
  logic [16:0] fold1;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (first_i) acc_d = {1'b0, word_i};
      else         acc_d = {1'b0, acc_q[15:0]} + {1'b0, word_i} + {16'b0, acc_q[16]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Two folds: the first carry add can itself carry when acc_q = 1_FFFF.
  assign fold1 = {1'b0, acc_q[15:0]} + {16'b0, acc_q[16]};
  assign sum_o = fold1[15:0] + {15'b0, fold1[16]};

endmodule

// File: rtl/udp_rx_parser.sv
// UDP/IPv4/Ethernet receive parser: captures the 42-byte header, filters on
// local MAC/IP/port, forwards the trimmed UDP payload. Optional IPv4 header
// checksum check is enabled by defining UDP_RX_IP_CSUM_CHECK_EN.
module udp_rx_parser
  import rgmii_pkg::*;
#(
  parameter int HDR_BYTES = 42,
  parameter int CNT_W     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [47:0]                         local_mac_i,
  input  logic [31:0]                         local_ip_i,
  input  logic [15:0]                         local_port_i,
  input  logic [7:0]                          s_axis_tdata_i,
  input  logic                                s_axis_tvalid_i,
  input  logic                                s_axis_tlast_i,
  input  logic                                s_axis_tuser_i,
  output logic                                s_axis_tready_o,
  output logic [7:0]                          m_axis_tdata_o,
  output logic                                m_axis_tvalid_o,
  output logic                                m_axis_tlast_o,
  output logic                                m_axis_tuser_o,
  input  logic                                m_axis_tready_i,
  output logic [$bits(ethernet_header_t)-1:0] hdr_o,
  output logic                                hdr_valid_o,
  output logic [CNT_W-1:0]                    drop_cnt_o
);

  localparam logic [5:0] LAST_BYTE = 6'(HDR_BYTES - 1);
  localparam int         HW        = $bits(ethernet_header_t);

  rx_state_t        state_q, state_d;
  logic [5:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [HW-1:0]    cap_q, hdr_full, hdr_q;
  logic             hdr_valid_q;
  logic             drop_inc, hdr_load, hdr_byte_acc;
  logic             hdr_ok, csum_ok;
  logic [15:0]      udp_len;
  ethernet_header_t hdr_chk;
  logic             s_tready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The byte in flight is merged so the last header byte is checked this cycle.
  always_comb begin
    hdr_full = cap_q;
    hdr_full[{byte_cnt_q, 3'b000} +: 8] = s_axis_tdata_i;
  end

  assign hdr_chk      = hdr_full;
  assign hdr_byte_acc = (state_q == ST_HEADER) && s_axis_tvalid_i;
  assign udp_len      = {hdr_chk.ipv4.udp.length[0], hdr_chk.ipv4.udp.length[1]};

  assign hdr_ok = ({hdr_chk.eth_type_length[0], hdr_chk.eth_type_length[1]} == ETH_TYPE_IPV4) &&
                  (hdr_chk.ipv4.version_ihl == IPV4_VER_IHL) &&
                  (hdr_chk.ipv4.protocol == IP_PROTO_UDP) &&
                  ((hdr_chk.mac_destination == local_mac_i) || (&hdr_chk.mac_destination)) &&
                  (hdr_chk.ipv4.ip_destination == local_ip_i) &&
                  (hdr_chk.ipv4.udp.port_destination == local_port_i) &&
                  (udp_len >= 16'(UDP_HDR_BYTES)) &&
                  csum_ok;

`ifdef UDP_RX_IP_CSUM_CHECK_EN
  logic [7:0]  csum_hi_q;
  logic        csum_en, csum_first;
  logic [15:0] csum_fold;

  // IPv4 header words are wire bytes 14..33; even byte is the high half.
  assign csum_en    = hdr_byte_acc && byte_cnt_q[0] && (byte_cnt_q >= 6'd15) && (byte_cnt_q <= 6'd33);
  assign csum_first = (byte_cnt_q == 6'd15);

  always_ff @(posedge clk_i) begin
    if (hdr_byte_acc && !byte_cnt_q[0]) csum_hi_q <= s_axis_tdata_i;
  end

  ip_csum_acc u_csum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (csum_en),
    .first_i (csum_first),
    .word_i  ({csum_hi_q, s_axis_tdata_i}),
    .sum_o   (csum_fold)
  );

  assign csum_ok = (csum_fold == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    pay_cnt_d       = pay_cnt_q;
    drop_inc        = 1'b0;
    hdr_load        = 1'b0;
    s_tready        = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = 8'h00;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = 1'b0;
    unique case (state_q)
      ST_HEADER: begin
        s_tready = 1'b1;
        if (s_axis_tvalid_i) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (hdr_ok) begin
              hdr_load  = 1'b1;
              pay_cnt_d = udp_len - 16'(UDP_HDR_BYTES);
              if (s_axis_tlast_i) begin
                // Header-only frame whose UDP length promised payload.
                drop_inc = (udp_len != 16'(UDP_HDR_BYTES));
              end else begin
                state_d = (udp_len == 16'(UDP_HDR_BYTES)) ? ST_DROP : ST_PAYLOAD;
              end
            end else begin
              drop_inc = 1'b1;
              state_d  = s_axis_tlast_i ? ST_HEADER : ST_DROP;
            end
          end else if (s_axis_tlast_i) begin
            byte_cnt_d = '0;
            drop_inc   = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        s_tready        = m_axis_tready_i;
        m_axis_tvalid_o = s_axis_tvalid_i;
        m_axis_tdata_o  = s_axis_tdata_i;
        if (pay_cnt_q == 16'd1) begin
          m_axis_tlast_o = 1'b1;
          m_axis_tuser_o = s_axis_tlast_i && s_axis_tuser_i;
        end else if (s_axis_tlast_i) begin
          m_axis_tlast_o = 1'b1;
          m_axis_tuser_o = 1'b1;
        end
        if (s_axis_tvalid_i && m_axis_tready_i) begin
          pay_cnt_d = pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) begin
            state_d = s_axis_tlast_i ? ST_HEADER : ST_DROP;
          end else if (s_axis_tlast_i) begin
            state_d  = ST_HEADER;
            drop_inc = 1'b1;
          end
        end
      end
      ST_DROP: begin
        s_tready = 1'b1;
        if (s_axis_tvalid_i && s_axis_tlast_i) state_d = ST_HEADER;
      end
      default: state_d = ST_HEADER;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HEADER;
      byte_cnt_q  <= '0;
      pay_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_valid_q <= hdr_load;
      if (drop_inc) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (hdr_load) hdr_q <= hdr_full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hdr_byte_acc) cap_q <= hdr_full;
  end

  assign s_axis_tready_o = s_tready && !rst_i;
  assign hdr_o           = hdr_q;
  assign hdr_valid_o     = hdr_valid_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: directed frames, expected payload beats
// and header lengths queued at stimulus time, checked by an independent monitor.
module tb_udp_rx_parser;
  import rgmii_pkg::*;

  localparam logic [47:0] LMAC  = 48'h01_00_00_00_00_02;
  localparam logic [31:0] LIP   = 32'h0A_01_A8_C0;
  localparam logic [15:0] LPORT = 16'hD204;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [$bits(ethernet_header_t)-1:0] hdr_o;
  logic        hdr_valid;
  logic [15:0] drop_cnt;
  ethernet_header_t hdr_view;

  udp_rx_parser dut (
    .clk_i(clk), .rst_i(rst),
    .local_mac_i(LMAC), .local_ip_i(LIP), .local_port_i(LPORT),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tuser_i(s_tuser), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
    .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_tready),
    .hdr_o(hdr_o), .hdr_valid_o(hdr_valid), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;
  assign hdr_view = hdr_o;

  logic [9:0]  frm[$];
  logic [9:0]  exp_q[$];
  logic [15:0] exp_len_q[$];
  int checks = 0, errors = 0;
  int stall_cnt = 0;
  int exp_drop = 0;
  bit tog_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pb(input logic [7:0] d);
    frm.push_back({2'b00, d});
  endtask

  task automatic end_frame(input bit user);
    logic [9:0] e;
    e = frm.pop_back();
    e[9] = 1'b1;
    e[8] = user;
    frm.push_back(e);
  endtask

  task automatic exp_byte(input logic [7:0] d, input bit l, input bit u);
    exp_q.push_back({l, u, d});
  endtask

  // Builds a 42-byte header; multi-byte args are natural big-endian values.
  task automatic push_hdr(input logic [47:0] dmac, input logic [15:0] etype,
                          input logic [31:0] dip, input logic [15:0] dport,
                          input logic [15:0] ulen, input bit bad_csum);
    logic [7:0]  h[42];
    logic [15:0] tl, cs;
    logic [31:0] s;
    for (int i = 0; i < 42; i++) h[i] = 8'h00;
    for (int i = 0; i < 6; i++) h[i] = dmac[47-8*i -: 8];
    h[6] = 8'h02; h[11] = 8'h02;
    h[12] = etype[15:8]; h[13] = etype[7:0];
    h[14] = 8'h45;
    tl = 16'd20 + ulen;
    h[16] = tl[15:8]; h[17] = tl[7:0];
    h[22] = 8'h40; h[23] = 8'h11;
    h[26] = 8'hC0; h[27] = 8'hA8; h[28] = 8'h01; h[29] = 8'h14;
    for (int i = 0; i < 4; i++) h[30+i] = dip[31-8*i -: 8];
    h[34] = 8'h13; h[35] = 8'h88;
    h[36] = dport[15:8]; h[37] = dport[7:0];
    h[38] = ulen[15:8];  h[39] = ulen[7:0];
    s = 0;
    for (int w = 14; w < 34; w += 2) s = s + {16'h0, h[w], h[w+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    if (bad_csum) cs = cs ^ 16'h0100;
    h[24] = cs[15:8]; h[25] = cs[7:0];
    for (int i = 0; i < 42; i++) pb(h[i]);
  endtask

  task automatic send_byte(input logic [9:0] e);
    bit ok;
    @(negedge clk);
    s_tdata = e[7:0]; s_tuser = e[8]; s_tlast = e[9]; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      #1 ok = s_tready;
      @(posedge clk);
      if (!ok) begin
        stall_cnt++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no s_tready expected accept");
    end
  endtask

  task automatic send_all();
    while (frm.size() > 0) send_byte(frm.pop_front());
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT presents output.
  initial begin
    logic [9:0]  e;
    logic [15:0] l;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_tvalid) begin
        check("tready_mirror", {63'h0, s_tready}, {63'h0, m_tready});
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h expected none", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("m_tdata", {56'h0, m_tdata}, {56'h0, e[7:0]});
            check("m_tlast", {63'h0, m_tlast}, {63'h0, e[9]});
            check("m_tuser", {63'h0, m_tuser}, {63'h0, e[8]});
          end
        end
      end
      if (!rst && hdr_valid) begin
        if (exp_len_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hdr: got hdr_valid expected none");
        end else begin
          l = exp_len_q.pop_front();
          check("hdr_udp_len", {48'h0, hdr_view.ipv4.udp.length[0], hdr_view.ipv4.udp.length[1]}, {48'h0, l});
          check("hdr_dport", {48'h0, hdr_view.ipv4.udp.port_destination}, {48'h0, LPORT});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_tready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        m_tready = tog_en ? ~m_tready : 1'b1;
      end
    join_none
    idle(4);
    check("rst_m_tvalid", {63'h0, m_tvalid}, 64'h0);
    check("rst_s_tready", {63'h0, s_tready}, 64'h0);
    check("rst_hdr_valid", {63'h0, hdr_valid}, 64'h0);
    check("rst_drop_cnt", {48'h0, drop_cnt}, 64'h0);
    check("rst_hdr", {63'h0, |hdr_o}, 64'h0);
    rst = 1'b0;
    idle(2);
    check("hdr_s_tready", {63'h0, s_tready}, 64'h1);

    // Basic frame, UDP length 12
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd12, 1'b0);
    pb(8'hDE); pb(8'hAD); pb(8'hBE); pb(8'hEF); end_frame(1'b0);
    exp_byte(8'hDE, 0, 0); exp_byte(8'hAD, 0, 0); exp_byte(8'hBE, 0, 0); exp_byte(8'hEF, 1, 0);
    exp_len_q.push_back(16'd12);
    send_all(); idle(4);
    check("drop_basic", {48'h0, drop_cnt}, 64'h0);

    // Padded frame followed back-to-back by another frame
    stall_cnt = 0;
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd12, 1'b0);
    pb(8'hDE); pb(8'hAD); pb(8'hBE); pb(8'hEF);
    for (int i = 0; i < 14; i++) pb(8'h00);
    end_frame(1'b0);
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd10, 1'b0);
    pb(8'h11); pb(8'h22); end_frame(1'b0);
    exp_byte(8'hDE, 0, 0); exp_byte(8'hAD, 0, 0); exp_byte(8'hBE, 0, 0); exp_byte(8'hEF, 1, 0);
    exp_byte(8'h11, 0, 0); exp_byte(8'h22, 1, 0);
    exp_len_q.push_back(16'd12); exp_len_q.push_back(16'd10);
    send_all(); idle(4);
    check("pad_no_stall", stall_cnt, 64'h0);
    check("drop_pad", {48'h0, drop_cnt}, 64'h0);

    // Three rejected frames: wrong port, IPv6 EtherType, runt
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1235, 16'd12, 1'b0);
    pb(8'h01); pb(8'h02); pb(8'h03); pb(8'h04); end_frame(1'b0);
    push_hdr(48'h020000000001, 16'h86DD, 32'hC0A8010A, 16'd1234, 16'd12, 1'b0);
    pb(8'h01); pb(8'h02); pb(8'h03); pb(8'h04); end_frame(1'b0);
    for (int i = 0; i < 20; i++) pb(8'(i + 8'h30));
    end_frame(1'b0);
    send_all(); idle(4);
    exp_drop += 3;
    check("drop_reject3", {48'h0, drop_cnt}, 64'(exp_drop));

    // Broadcast MAC, header-only datagram ending on the last header byte
    push_hdr(48'hFFFFFFFFFFFF, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd8, 1'b0);
    end_frame(1'b0);
    exp_len_q.push_back(16'd8);
    send_all(); idle(4);
    check("drop_bcast", {48'h0, drop_cnt}, 64'(exp_drop));

    // 64-byte payload with downstream backpressure toggling
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd72, 1'b0);
    for (int i = 0; i < 64; i++) begin
      pb(8'((i * 7 + 3) & 8'hFF));
      exp_byte(8'((i * 7 + 3) & 8'hFF), i == 63, 1'b0);
    end
    end_frame(1'b0);
    exp_len_q.push_back(16'd72);
    tog_en = 1'b1;
    send_all();
    tog_en = 1'b0;
    idle(4);
    check("drop_tog", {48'h0, drop_cnt}, 64'(exp_drop));

    // Truncated frame: UDP length 100, only 10 payload bytes arrive
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pb(8'(8'hA0 + i));
      exp_byte(8'(8'hA0 + i), i == 9, i == 9);
    end
    end_frame(1'b0);
    exp_len_q.push_back(16'd100);
    send_all(); idle(4);
    exp_drop += 1;
    check("drop_trunc", {48'h0, drop_cnt}, 64'(exp_drop));

    // Error flag on final payload byte
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd10, 1'b0);
    pb(8'hAA); pb(8'hBB); end_frame(1'b1);
    exp_byte(8'hAA, 0, 0); exp_byte(8'hBB, 1, 1);
    exp_len_q.push_back(16'd10);
    send_all(); idle(4);
    check("drop_tuser", {48'h0, drop_cnt}, 64'(exp_drop));

    // Corrupted IPv4 header checksum
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd10, 1'b1);
    pb(8'h55); pb(8'h66); end_frame(1'b0);
`ifdef UDP_RX_IP_CSUM_CHECK_EN
    exp_drop += 1;
`else
    exp_byte(8'h55, 0, 0); exp_byte(8'h66, 1, 0);
    exp_len_q.push_back(16'd10);
`endif
    send_all(); idle(4);
    check("drop_csum", {48'h0, drop_cnt}, 64'(exp_drop));

    // Good frame after the checksum case is still accepted
    push_hdr(48'h020000000001, 16'h0800, 32'hC0A8010A, 16'd1234, 16'd9, 1'b0);
    pb(8'h77); end_frame(1'b0);
    exp_byte(8'h77, 1, 0);
    exp_len_q.push_back(16'd9);
    send_all(); idle(10);
    check("drop_final", {48'h0, drop_cnt}, 64'(exp_drop));

    check("beats_pending", exp_q.size(), 64'h0);
    check("hdrs_pending", exp_len_q.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
